// File: rtl/ffd_bank_arbiter.sv
// ---------------------------------------------------------------------------
// ffd_bank_arbiter
//
// Round-robin write arbiter and sequencer for a bank of NREG enabled
// D-register words. Two requesters share one write path. A request seen in
// IDLE is captured with the winner's address and data. The following WRITE
// cycle drives a one-hot word enable and acks the winner, and the word
// updates at the end of that cycle.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset (clears bank, FSM, pointer)
//   req0/addr0/data0  requester 0 write request (level), target word, data
//   req1/addr1/data1  requester 1 write request (level), target word, data
//   ack0, ack1     one-cycle pulse: that requester's write is committed
//   busy           high while in WRITE
//   wr_en          one-hot word enable currently applied to the bank
//   rd_addr        combinational read address
//   rd_data        bank word rd_addr (old value during its own WRITE)
//   bank_q         all words, word i at [i*DATA_W +: DATA_W]
//
// NREG must equal 2**ADDR_W, so every address names a real word.
// ---------------------------------------------------------------------------
module ffd_bank_arbiter #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 2,
   parameter int NREG   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0,
   input  logic [ADDR_W-1:0]        addr0,
   input  logic [DATA_W-1:0]        data0,
   input  logic                     req1,
   input  logic [ADDR_W-1:0]        addr1,
   input  logic [DATA_W-1:0]        data1,
   output logic                     ack0,
   output logic                     ack1,
   output logic                     busy,
   output logic [NREG-1:0]          wr_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic [NREG*DATA_W-1:0]   bank_q
);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t              state, state_nx;
   logic                ptr;        // requester that wins a tie (0 or 1)
   logic                grant;      // winner of the current IDLE arbitration
   logic                win_id;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_data;
   logic [DATA_W-1:0]   bank [NREG];

   // Tie goes to the pointer. Otherwise the single requester wins, and with
   // req1 low that is requester 0.
   assign grant = (req0 && req1) ? ptr : req1;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         win_id   <= 1'b0;
         win_addr <= '0;
         win_data <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && (req0 || req1)) begin
            win_id   <= grant;
            win_addr <= grant ? addr1 : addr0;
            win_data <= grant ? data1 : data0;
         end
         // The loser gets the next tie, whether or not it was requesting.
         if (state == WRITE) begin
            ptr <= ~win_id;
         end
      end
   end

   // NOTE: every output of this block is given a default before the case, so
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      wr_en    = '0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nx = WRITE;
            end
         end
         WRITE: begin
            state_nx = IDLE;
            // A reset landing on the WRITE cycle aborts it. The enable and
            // ack are suppressed so no requester believes a write happened.
            if (!rst) begin
               busy            = 1'b1;
               wr_en[win_addr] = 1'b1;
               ack0            = ~win_id;
               ack1            = win_id;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Storage: one enabled register per word.
   // NOTE: the bank is built from flip-flops rather than a RAM macro, so
   // clearing it on reset is legal and each word carries its own reset.
   for (genvar i = 0; i < NREG; i++) begin : g_word
      always_ff @(posedge clk) begin
         if (rst) begin
            bank[i] <= '0;
         end else if (wr_en[i]) begin
            bank[i] <= win_data;
         end
      end
      assign bank_q[i*DATA_W +: DATA_W] = bank[i];
   end

   assign rd_data = bank[rd_addr];

endmodule
